// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small write FIFO.
// Host bytes are queued in the FIFO and sent on tx as start bit, 8 data
// bits LSB-first and one stop bit. Back-to-back frames have no idle gap.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-low reset
//   i_dat       byte to transmit, sampled when i_wr is high
//   i_wr        write strobe, one byte per high cycle
//   tx          serial line, idle high, registered
//   o_full      FIFO holds FIFO_DEPTH entries
//   o_empty     FIFO holds no entries
//   o_busy      a frame is on the line
//   o_done      one-cycle pulse after a frame's stop bit completes
//   o_overflow  one-cycle pulse after a write dropped on a full FIFO
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 1250,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] i_dat,
    input  logic       i_wr,
    output logic       tx,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_overflow
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [7:0]       shift, shift_nx;
    logic             bit_end;
    logic             tx_nx;
    logic             done_nx;
    logic             pop;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_nx;
    logic             wr_ok;
    logic [7:0]       head;

    // A write is judged against the pre-edge full flag; a same-edge pop does not make room.
    assign wr_ok    = i_wr && !o_full;
    assign head     = mem[rd_ptr];
    assign level_nx = level + LVL_W'(wr_ok) - LVL_W'(pop);
    assign bit_end  = (bit_cnt == BIT_LAST);

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= i_dat;
        end
    end

    // FIFO pointers, occupancy and flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level   <= level_nx;
            o_full  <= (level_nx == LVL_FULL);
            o_empty <= (level_nx == '0);
        end
    end

    // FSM and datapath state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
        end
    end

    // Next-state, FIFO pop and next line value.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        pop        = 1'b0;
        done_nx    = 1'b0;
        tx_nx      = 1'b1;

        case (state)
            IDLE: begin
                bit_cnt_nx = '0;
                if (!o_empty) begin
                    pop        = 1'b1;
                    shift_nx   = head;
                    bit_idx_nx = '0;
                    state_nx   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_nx = '0;
                    state_nx   = DATA;
                end else begin
                    bit_cnt_nx = bit_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_nx = '0;
                    shift_nx   = {1'b0, shift[7:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_nx = '0;
                    done_nx    = 1'b1;
                    // Chain straight into the next start bit when more data is queued.
                    if (!o_empty) begin
                        pop        = 1'b1;
                        shift_nx   = head;
                        bit_idx_nx = '0;
                        state_nx   = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Line value follows the state being entered so tx changes with the state flop.
        case (state_nx)
            IDLE:    tx_nx = 1'b1;
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            STOP:    tx_nx = 1'b1;
            default: tx_nx = 1'b1;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx         <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            tx         <= tx_nx;
            o_busy     <= (state_nx != IDLE);
            o_done     <= done_nx;
            o_overflow <= i_wr && o_full;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_uart_tx;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clock;
    logic       reset;
    logic [7:0] i_dat;
    logic       i_wr;
    logic       tx;
    logic       o_full;
    logic       o_empty;
    logic       o_busy;
    logic       o_done;
    logic       o_overflow;

    int n_assert;
    int n_fail;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_dat     (i_dat),
        .i_wr      (i_wr),
        .tx        (tx),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_overflow(o_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level at frame cycle c (c=0 is the start-bit fall).
    function automatic logic frame_bit(input logic [7:0] b, input int c);
        int k;
        k = c / int'(CPB);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Checks a frame cycle by cycle from cycle start_c; returns at frame cycle 160.
    task automatic check_frame(input logic [7:0] b, input bit more, input int start_c,
                               input bit wr_end);
        for (int c = start_c; c < int'(FRAME); c++) begin
            chk($sformatf("tx_%02h_c%0d", b, c), 32'(tx), 32'(frame_bit(b, c)));
            chk($sformatf("busy_%02h_c%0d", b, c), 32'(o_busy), 32'd1);
            if (c > 0) chk($sformatf("done_%02h_c%0d", b, c), 32'(o_done), 32'd0);
            if (c > start_c) chk($sformatf("ovf_%02h_c%0d", b, c), 32'(o_overflow), 32'd0);
            if (wr_end && c == int'(FRAME) - 1) begin
                i_dat = 8'hEE;
                i_wr  = 1'b1;
            end
            @(negedge clock);
        end
        i_wr = 1'b0;
        chk($sformatf("done_%02h_end", b), 32'(o_done), 32'd1);
        chk($sformatf("tx_%02h_end", b), 32'(tx), more ? 32'd0 : 32'd1);
        chk($sformatf("busy_%02h_end", b), 32'(o_busy), 32'(more));
    endtask

    // Bounded wait for the start-bit fall.
    task automatic wait_fall(input int max_cycles);
        for (int i = 0; i < max_cycles && tx !== 1'b0; i++) @(negedge clock);
        chk("tx_fall", 32'(tx), 32'd0);
    endtask

    // Mid-bit sampling receiver; entered at frame cycle 0, returns at cycle 152.
    task automatic rx_byte(output logic [7:0] data, output logic start_b, output logic stop_b);
        repeat (CPB / 2) @(negedge clock);
        start_b = tx;
        for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clock);
            data[b] = tx;
        end
        repeat (CPB) @(negedge clock);
        stop_b = tx;
    endtask

    initial begin
        logic [7:0] bytes_q [6];
        logic [7:0] lb      [3];
        logic [7:0] rx_d;
        logic       rx_s0;
        logic       rx_s1;
        int         bad;

        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        i_dat    = 8'h00;
        i_wr     = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_tx", 32'(tx), 32'd1);

        // Single byte 0xA5: tx falls two edges after the write
        i_dat = 8'hA5;
        i_wr  = 1'b1;
        @(negedge clock);
        i_wr = 1'b0;
        chk("a5_tx_e0", 32'(tx), 32'd1);
        chk("a5_empty_e0", 32'(o_empty), 32'd0);
        chk("a5_busy_e0", 32'(o_busy), 32'd0);
        @(negedge clock);
        chk("a5_empty_e1", 32'(o_empty), 32'd1);
        check_frame(8'hA5, 1'b0, 0, 1'b0);
        @(negedge clock);
        chk("a5_done_after", 32'(o_done), 32'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
            @(negedge clock);
        end
        chk("a5_idle_after", 32'(bad), 32'd0);

        // Burst of six writes: 0x00..0x44 kept, 0x55 dropped
        bytes_q = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 6; i++) begin
            i_dat = bytes_q[i];
            i_wr  = 1'b1;
            @(negedge clock);
            chk($sformatf("burst_ovf_%0d", i), 32'(o_overflow), (i == 5) ? 32'd1 : 32'd0);
            chk($sformatf("burst_full_%0d", i), 32'(o_full), (i >= 4) ? 32'd1 : 32'd0);
        end
        i_wr = 1'b0;
        check_frame(8'h00, 1'b1, 4, 1'b0);
        check_frame(8'h11, 1'b1, 0, 1'b0);
        check_frame(8'h22, 1'b1, 0, 1'b0);
        check_frame(8'h33, 1'b1, 0, 1'b0);
        check_frame(8'h44, 1'b0, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || o_done !== 1'b0) bad++;
        end
        chk("burst_no_55", 32'(bad), 32'd0);
        chk("burst_empty", 32'(o_empty), 32'd1);

        // Full FIFO with a write on the STOP->START pop edge
        bytes_q = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hC3, 8'h00};
        for (int i = 0; i < 5; i++) begin
            i_dat = bytes_q[i];
            i_wr  = 1'b1;
            @(negedge clock);
        end
        i_wr = 1'b0;
        chk("fp_full_before", 32'(o_full), 32'd1);
        check_frame(8'h81, 1'b1, 3, 1'b1);
        chk("fp_ovf", 32'(o_overflow), 32'd1);
        chk("fp_full_after", 32'(o_full), 32'd0);
        @(negedge clock);
        chk("fp_ovf_pulse", 32'(o_overflow), 32'd0);
        check_frame(8'h42, 1'b1, 1, 1'b0);
        check_frame(8'h24, 1'b1, 0, 1'b0);
        check_frame(8'h18, 1'b1, 0, 1'b0);
        check_frame(8'hC3, 1'b0, 0, 1'b0);
        repeat (20) @(negedge clock);
        chk("fp_no_ee_tx", 32'(tx), 32'd1);
        chk("fp_empty", 32'(o_empty), 32'd1);

        // Loopback through the bench receiver
        lb = '{8'h00, 8'hFF, 8'h3C};
        for (int i = 0; i < 3; i++) begin
            i_dat = lb[i];
            i_wr  = 1'b1;
            @(negedge clock);
            i_wr = 1'b0;
            wait_fall(8);
            rx_byte(rx_d, rx_s0, rx_s1);
            chk($sformatf("lb_start_%0d", i), 32'(rx_s0), 32'd0);
            chk($sformatf("lb_data_%0d", i), 32'(rx_d), 32'(lb[i]));
            chk($sformatf("lb_stop_%0d", i), 32'(rx_s1), 32'd1);
            repeat (CPB) @(negedge clock);
        end

        // Reset during data bit 3 of 0x5A with two bytes queued
        bytes_q = '{8'h5A, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            i_dat = bytes_q[i];
            i_wr  = 1'b1;
            @(negedge clock);
        end
        i_wr = 1'b0;
        chk("mr_empty_before", 32'(o_empty), 32'd0);
        repeat (69) @(negedge clock);
        chk("mr_tx_bit3", 32'(tx), 32'd1);
        chk("mr_busy_before", 32'(o_busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mr_tx", 32'(tx), 32'd1);
        chk("mr_empty", 32'(o_empty), 32'd1);
        chk("mr_busy", 32'(o_busy), 32'd0);
        chk("mr_done", 32'(o_done), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b0) bad++;
        end
        chk("mr_idle_after", 32'(bad), 32'd0);
        chk("mr_empty_after", 32'(o_empty), 32'd1);

        // Normal operation resumes after the reset
        i_dat = 8'h3C;
        i_wr  = 1'b1;
        @(negedge clock);
        i_wr = 1'b0;
        chk("post_tx_e0", 32'(tx), 32'd1);
        @(negedge clock);
        check_frame(8'h3C, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
